// File: rtl/mem_preload_sequencer.sv
// Preload/run/dump sequencer driving the HLS main top through slave channel 0.
// Loads a byte stream, pulses start, times the run, then streams results out.
module mem_preload_sequencer #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int SIZE_W     = 4,
  parameter int MAX_CYCLES = 200000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [15:0]         cfg_load_len,
  input  logic [15:0]         cfg_dump_len,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic [1:0]          S_oe_ram,
  output logic [1:0]          S_we_ram,
  output logic [2*ADDR_W-1:0] S_addr_ram,
  output logic [2*DATA_W-1:0] S_Wdata_ram,
  output logic [2*SIZE_W-1:0] S_data_ram_size,
  input  logic [2*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [1:0]          Sout_DataRdy,
  output logic                start_port,
  input  logic                done_port,
  output logic                out_valid,
  output logic [7:0]          out_data,
  input  logic                out_ready,
  output logic                busy,
  output logic [31:0]         cycle_count,
  output logic                timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN,
    S_RD_REQ, S_RD_WAIT, S_RD_OUT, S_FIN
  } state_t;

  localparam logic [31:0] LP_MAX = 32'(MAX_CYCLES);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_base;
  logic [15:0]         r_load_len;
  logic [15:0]         r_dump_len;
  logic [15:0]         r_idx;
  logic [31:0]         r_cycle_count;
  logic                r_timeout;
  logic [7:0]          r_out_data;

  logic [ADDR_W-1:0]   w_addr;
  logic [31:0]         w_cnt_nxt;
  logic                w_last_load;
  logic                w_last_dump;
  logic                w_we;
  logic                w_oe;
  logic                w_acc;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_unused;

  assign w_addr      = r_base + r_idx[ADDR_W-1:0];
  assign w_cnt_nxt   = r_cycle_count + 32'd1;
  assign w_last_load = (r_idx == r_load_len - 16'd1);
  assign w_last_dump = (r_idx == r_dump_len - 16'd1);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    cfg_ready  = 1'b0;
    in_ready   = 1'b0;
    w_we       = 1'b0;
    w_oe       = 1'b0;
    start_port = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (cfg_valid)
          w_next = (cfg_load_len == 16'd0) ? S_START : S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_we = 1'b1;
          if (w_last_load) w_next = S_START;
        end
      end
      S_START: begin
        start_port = 1'b1;
        w_next     = done_port ? S_RD_REQ : S_RUN;
      end
      S_RUN: begin
        if (done_port)              w_next = S_RD_REQ;
        else if (w_cnt_nxt >= LP_MAX) w_next = S_FIN;
      end
      S_RD_REQ: begin
        if (r_dump_len == 16'd0) begin
          w_next = S_FIN;
        end else begin
          w_oe   = 1'b1;
          w_next = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (Sout_DataRdy[0]) w_next = S_RD_OUT;
      end
      S_RD_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = w_last_dump ? S_FIN : S_RD_REQ;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_base        <= '0;
      r_load_len    <= '0;
      r_dump_len    <= '0;
      r_idx         <= '0;
      r_cycle_count <= '0;
      r_timeout     <= 1'b0;
      r_out_data    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cfg_valid) begin
            r_base        <= cfg_base_addr;
            r_load_len    <= cfg_load_len;
            r_dump_len    <= cfg_dump_len;
            r_idx         <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
          end
        end
        S_LOAD: begin
          // Index restarts at zero so the dump reads back from the base.
          if (in_valid) r_idx <= w_last_load ? 16'd0 : r_idx + 16'd1;
        end
        S_START: r_cycle_count <= 32'd1;
        S_RUN: begin
          r_cycle_count <= w_cnt_nxt;
          if (!done_port && w_cnt_nxt >= LP_MAX) r_timeout <= 1'b1;
        end
        S_RD_WAIT: begin
          if (Sout_DataRdy[0]) r_out_data <= Sout_Rdata_ram[7:0];
        end
        S_RD_OUT: begin
          if (out_ready) r_idx <= r_idx + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_acc   = w_we | w_oe;
  assign w_wdata = w_we ? DATA_W'(in_data) : {DATA_W{1'b0}};

  assign S_we_ram        = {1'b0, w_we};
  assign S_oe_ram        = {1'b0, w_oe};
  assign S_addr_ram      = {{ADDR_W{1'b0}},
                            w_acc ? w_addr : {ADDR_W{1'b0}}};
  assign S_Wdata_ram     = {{DATA_W{1'b0}}, w_wdata};
  assign S_data_ram_size = {{SIZE_W{1'b0}},
                            w_acc ? SIZE_W'(8) : {SIZE_W{1'b0}}};

  assign out_data    = r_out_data;
  assign cycle_count = r_cycle_count;
  assign timeout     = r_timeout;

  assign w_unused = ^{Sout_Rdata_ram[2*DATA_W-1:8], Sout_DataRdy[1]};

endmodule
